// File: rtl/wide_sort_pipe_if.sv
// Stream bundle for wide_sort_pipe: input vector handshake plus sorted output
// handshake. The slave modport is the sorter's view; master is the
// producer/consumer environment driving it.
//
// Handshake: a beat transfers on a rising Clk edge where valid && ready are
// both high. A producer holds valid and its payload until that edge.
// ready may depend combinationally on the other side's ready (InReady follows
// OutReady), never on the same side's valid.
interface wide_sort_pipe_if #(
    parameter int N = 4,
    parameter int M = 4
);
    localparam int IW = $clog2(M);

    logic                  InValid;
    logic                  InReady;
    logic                  Descend;
    logic [M-1:0][N-1:0]   X;
    logic                  OutValid;
    logic                  OutReady;
    logic [M-1:0][N-1:0]   Y;
    logic [M-1:0][IW-1:0]  YIdx;
    logic                  OutDescend;

    modport master (
        output InValid, Descend, X, OutReady,
        input  InReady, OutValid, Y, YIdx, OutDescend
    );

    modport slave (
        input  InValid, Descend, X, OutReady,
        output InReady, OutValid, Y, YIdx, OutDescend
    );
endinterface

// File: rtl/wide_sort_pipe.sv
// Pipelined stable argsort: M registered odd-even transposition layers.
// Each stage carries a valid bit, M keys, M original-lane tags and the
// sort direction. The whole pipe advances together whenever the output
// register is empty or being taken, so bubbles are not squeezed out.
module wide_sort_pipe #(
    parameter int N      = 4,
    parameter int M      = 4,
    parameter bit SIGNED = 1'b0
) (
    input  logic                   Clk,
    input  logic                   Reset,
    wide_sort_pipe_if.slave        strm,
    output logic [$clog2(M+1)-1:0] Occupancy
);
    localparam int IW = $clog2(M);
    localparam int OW = $clog2(M+1);

    typedef logic [M-1:0][N-1:0]  keys_t;
    typedef logic [M-1:0][IW-1:0] tags_t;

    // Stage registers: index k holds stage S(k+1); index M-1 is the output stage.
    keys_t        key_q [M];
    tags_t        idx_q [M];
    logic [M-1:0] vld_q;
    logic [M-1:0] desc_q;
    logic [OW-1:0] occ_q, occ_d;

    // Layer k reads src_* and produces the next contents of stage k.
    keys_t        src_key [M];
    tags_t        src_idx [M];
    logic [M-1:0] src_vld;
    logic [M-1:0] src_desc;
    keys_t        key_d [M];
    tags_t        idx_d [M];

    logic advance;
    logic accept;
    logic consume;

    // Strict "a > b" in the configured number format; keys are never widened.
    function automatic logic key_gt(input logic [N-1:0] a, input logic [N-1:0] b);
        logic r;
        if (SIGNED) r = $signed(a) > $signed(b);
        else        r = a > b;
        return r;
    endfunction

    // Equal keys swap only when the tags are out of order, which keeps the sort stable.
    function automatic logic need_swap(input logic [N-1:0] ka, input logic [N-1:0] kb,
                                       input logic [IW-1:0] ia, input logic [IW-1:0] ib,
                                       input logic desc);
        logic tie_swap;
        logic r;
        tie_swap = (ka == kb) && (ia > ib);
        if (desc) r = key_gt(kb, ka) || tie_swap;
        else      r = key_gt(ka, kb) || tie_swap;
        return r;
    endfunction

    // Whole-pipe flow control: move when the output stage is empty or being taken.
    assign advance       = !vld_q[M-1] || strm.OutReady;
    assign accept        = strm.InValid && advance;
    assign consume       = vld_q[M-1] && strm.OutReady;
    assign strm.InReady  = advance;

    assign strm.OutValid   = vld_q[M-1];
    assign strm.Y          = key_q[M-1];
    assign strm.YIdx       = idx_q[M-1];
    assign strm.OutDescend = desc_q[M-1];
    assign Occupancy       = occ_q;

    // Layer inputs: layer 0 sees the offered vector with fresh tags 0..M-1,
    // every later layer sees the previous stage's registers.
    always_comb begin
        src_key[0]  = strm.X;
        src_vld[0]  = strm.InValid;
        src_desc[0] = strm.Descend;
        for (int l = 0; l < M; l++) begin
            src_idx[0][l] = IW'(l);
        end
        for (int k = 1; k < M; k++) begin
            src_key[k]  = key_q[k-1];
            src_idx[k]  = idx_q[k-1];
            src_vld[k]  = vld_q[k-1];
            src_desc[k] = desc_q[k-1];
        end
    end

    // Compare-exchange layers: even layers pair (0,1),(2,3)..., odd layers (1,2),(3,4)...
    always_comb begin
        for (int k = 0; k < M; k++) begin
            key_d[k] = src_key[k];
            idx_d[k] = src_idx[k];
            for (int i = k % 2; i < M - 1; i += 2) begin
                if (need_swap(src_key[k][i], src_key[k][i+1],
                              src_idx[k][i], src_idx[k][i+1], src_desc[k])) begin
                    key_d[k][i]   = src_key[k][i+1];
                    key_d[k][i+1] = src_key[k][i];
                    idx_d[k][i]   = src_idx[k][i+1];
                    idx_d[k][i+1] = src_idx[k][i];
                end
            end
        end
    end

    // Occupancy tracks accepts minus consumes.
    always_comb begin
        occ_d = occ_q;
        if (accept && !consume) begin
            occ_d = occ_q + OW'(1);
        end else if (consume && !accept) begin
            occ_d = occ_q - OW'(1);
        end
    end

    // Pipeline registers: shift every stage together on advance, else hold.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            for (int k = 0; k < M; k++) begin
                key_q[k] <= '0;
                idx_q[k] <= '0;
            end
            vld_q  <= '0;
            desc_q <= '0;
            occ_q  <= '0;
        end else begin
            occ_q <= occ_d;
            if (advance) begin
                for (int k = 0; k < M; k++) begin
                    key_q[k] <= key_d[k];
                    idx_q[k] <= idx_d[k];
                end
                vld_q  <= src_vld;
                desc_q <= src_desc;
            end
        end
    end
endmodule

// File: tb/tb_wide_sort_pipe.sv
// Bench for wide_sort_pipe: main 4x4 unsigned instance with a scoreboard,
// plus a signed 4x4 instance and an odd-lane 5-lane instance.
module tb_wide_sort_pipe;

  typedef logic [3:0][3:0] k4_t;
  typedef logic [3:0][1:0] i4_t;
  typedef logic [4:0][3:0] k5_t;
  typedef logic [4:0][2:0] i5_t;

  typedef struct {
    k4_t  x;
    logic desc;
    k4_t  y;
    i4_t  yi;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic Clk = 1'b0;
  logic Reset = 1'b1;
  always #5 Clk = ~Clk;

  wide_sort_pipe_if #(.N(4), .M(4)) bus ();
  wide_sort_pipe_if #(.N(4), .M(4)) bus_s ();
  wide_sort_pipe_if #(.N(4), .M(5)) bus_o ();
  logic [2:0] occ, occ_s, occ_o;

  wide_sort_pipe #(.N(4), .M(4), .SIGNED(1'b0)) dut (
    .Clk(Clk), .Reset(Reset), .strm(bus), .Occupancy(occ));
  wide_sort_pipe #(.N(4), .M(4), .SIGNED(1'b1)) dut_s (
    .Clk(Clk), .Reset(Reset), .strm(bus_s), .Occupancy(occ_s));
  wide_sort_pipe #(.N(4), .M(5), .SIGNED(1'b0)) dut_o (
    .Clk(Clk), .Reset(Reset), .strm(bus_o), .Occupancy(occ_o));

  int n_cmp = 0;
  int n_fail = 0;
  logic [24:0] exp_q[$];
  vec_t tbl [9];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic k4_t k4(input int a, input int b, input int c, input int d);
    k4_t r;
    r[0] = 4'(a); r[1] = 4'(b); r[2] = 4'(c); r[3] = 4'(d);
    return r;
  endfunction

  function automatic i4_t i4(input int a, input int b, input int c, input int d);
    i4_t r;
    r[0] = 2'(a); r[1] = 2'(b); r[2] = 2'(c); r[3] = 2'(d);
    return r;
  endfunction

  function automatic k5_t k5(input int a, input int b, input int c, input int d, input int e);
    k5_t r;
    r[0] = 4'(a); r[1] = 4'(b); r[2] = 4'(c); r[3] = 4'(d); r[4] = 4'(e);
    return r;
  endfunction

  function automatic i5_t i5(input int a, input int b, input int c, input int d, input int e);
    i5_t r;
    r[0] = 3'(a); r[1] = 3'(b); r[2] = 3'(c); r[3] = 3'(d); r[4] = 3'(e);
    return r;
  endfunction

  // Reference: stable insertion sort of lane positions, unsigned keys.
  function automatic logic [24:0] model4(input k4_t x, input logic d);
    int ord[4];
    int t;
    logic [3:0] a, b;
    k4_t y;
    i4_t yi;
    for (int i = 0; i < 4; i++) ord[i] = i;
    for (int i = 1; i < 4; i++) begin
      for (int j = i; j > 0; j--) begin
        a = x[ord[j]];
        b = x[ord[j-1]];
        if (d ? (a > b) : (a < b)) begin
          t = ord[j]; ord[j] = ord[j-1]; ord[j-1] = t;
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      y[i]  = x[ord[i]];
      yi[i] = 2'(ord[i]);
    end
    return {y, yi, d};
  endfunction

  // ---------------- driver tasks (called at posedge+1) ----------------
  task automatic send(input k4_t x, input logic d, input logic [24:0] e);
    int tries = 0;
    logic acc = 1'b0;
    bus.InValid = 1'b1;
    bus.X       = x;
    bus.Descend = d;
    while (!acc) begin
      @(negedge Clk);
      acc = bus.InReady;
      if (acc) exp_q.push_back(e);
      @(posedge Clk); #1;
      tries++;
      if (!acc && tries > 200) begin
        n_cmp++; n_fail++;
        $display("FAIL send_timeout: InReady stayed %b for %0d cycles", bus.InReady, tries);
        acc = 1'b1;
      end
    end
    bus.InValid = 1'b0;
    bus.X       = k4_t'($urandom);
    bus.Descend = 1'($urandom_range(0, 1));
  endtask

  task automatic send_tbl(input int i);
    send(tbl[i].x, tbl[i].desc, {tbl[i].y, tbl[i].yi, tbl[i].desc});
  endtask

  task automatic send_rand(input int hi);
    k4_t x;
    logic d;
    for (int l = 0; l < 4; l++) x[l] = 4'($urandom_range(0, hi));
    d = 1'($urandom_range(0, 1));
    send(x, d, model4(x, d));
  endtask

  task automatic drain();
    int cyc = 0;
    bus.OutReady = 1'b1;
    while (exp_q.size() != 0 && cyc < 50) begin
      @(posedge Clk); #1;
      cyc++;
    end
    check("drain_queue_left", 64'(exp_q.size()), 64'd0);
    check("occ_after_drain", 64'(occ), 64'd0);
  endtask

  task automatic measure_latency(input string name, input int exp_lat);
    int lat = 0;
    while (!bus.OutValid && lat < 20) begin
      @(negedge Clk);
      lat++;
    end
    check(name, 64'(lat), 64'(exp_lat));
    @(posedge Clk); #1;
  endtask

  task automatic run_signed(input string name, input k4_t x, input logic d,
                            input k4_t ey, input i4_t ei);
    int lat = 0;
    bus_s.X = x; bus_s.Descend = d; bus_s.InValid = 1'b1;
    @(negedge Clk);
    check({name, "_inready"}, 64'(bus_s.InReady), 64'd1);
    @(posedge Clk); #1;
    bus_s.InValid = 1'b0; bus_s.X = k4_t'($urandom);
    while (!bus_s.OutValid && lat < 20) begin
      @(negedge Clk);
      lat++;
    end
    check({name, "_latency"}, 64'(lat), 64'd4);
    check({name, "_y"}, 64'(bus_s.Y), 64'(ey));
    check({name, "_yidx"}, 64'(bus_s.YIdx), 64'(ei));
    check({name, "_desc"}, 64'(bus_s.OutDescend), 64'(d));
    @(posedge Clk); #1;
  endtask

  task automatic run_odd(input string name, input k5_t x, input logic d,
                         input k5_t ey, input i5_t ei);
    int lat = 0;
    bus_o.X = x; bus_o.Descend = d; bus_o.InValid = 1'b1;
    @(negedge Clk);
    check({name, "_inready"}, 64'(bus_o.InReady), 64'd1);
    @(posedge Clk); #1;
    bus_o.InValid = 1'b0; bus_o.X = k5_t'($urandom);
    while (!bus_o.OutValid && lat < 20) begin
      @(negedge Clk);
      lat++;
    end
    check({name, "_latency"}, 64'(lat), 64'd5);
    check({name, "_y"}, 64'(bus_o.Y), 64'(ey));
    check({name, "_yidx"}, 64'(bus_o.YIdx), 64'(ei));
    check({name, "_desc"}, 64'(bus_o.OutDescend), 64'(d));
    @(posedge Clk); #1;
  endtask

  // ---------------- scoreboard monitor ----------------
  logic [24:0] mon_got, mon_exp;
  always @(negedge Clk) begin
    if (Reset && bus.OutValid && bus.OutReady) begin
      mon_got = {bus.Y, bus.YIdx, bus.OutDescend};
      if (exp_q.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL out_unexpected: got %h with no vector outstanding", mon_got);
      end else begin
        mon_exp = exp_q.pop_front();
        check("out_vector", 64'(mon_got), 64'(mon_exp));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  logic sending_done;
  logic [24:0] held;

  initial begin
    bus.InValid = 1'b0;   bus.Descend = 1'b0;   bus.X = '0;   bus.OutReady = 1'b1;
    bus_s.InValid = 1'b0; bus_s.Descend = 1'b0; bus_s.X = '0; bus_s.OutReady = 1'b1;
    bus_o.InValid = 1'b0; bus_o.Descend = 1'b0; bus_o.X = '0; bus_o.OutReady = 1'b1;

    tbl[0] = '{k4(8, 6, 1, 2),  1'b0, k4(1, 2, 6, 8),  i4(2, 3, 1, 0)};
    tbl[1] = '{k4(4, 4, 8, 0),  1'b0, k4(0, 4, 4, 8),  i4(3, 0, 1, 2)};
    tbl[2] = '{k4(4, 4, 8, 0),  1'b1, k4(8, 4, 4, 0),  i4(2, 0, 1, 3)};
    tbl[3] = '{k4(15, 2, 8, 0), 1'b0, k4(0, 2, 8, 15), i4(3, 1, 2, 0)};
    tbl[4] = '{k4(1, 2, 3, 4),  1'b0, k4(1, 2, 3, 4),  i4(0, 1, 2, 3)};
    tbl[5] = '{k4(8, 7, 7, 5),  1'b0, k4(5, 7, 7, 8),  i4(3, 1, 2, 0)};
    tbl[6] = '{k4(8, 8, 8, 8),  1'b0, k4(8, 8, 8, 8),  i4(0, 1, 2, 3)};
    tbl[7] = '{k4(8, 8, 8, 8),  1'b1, k4(8, 8, 8, 8),  i4(0, 1, 2, 3)};
    tbl[8] = '{k4(1, 2, 3, 4),  1'b1, k4(4, 3, 2, 1),  i4(3, 2, 1, 0)};

    // Reset state
    #1 Reset = 1'b0;
    #2;
    check("rst_outvalid", 64'(bus.OutValid), 64'd0);
    check("rst_inready", 64'(bus.InReady), 64'd1);
    check("rst_occ", 64'(occ), 64'd0);
    check("rst_y", 64'(bus.Y), 64'd0);
    check("rst_yidx_desc", 64'({bus.YIdx, bus.OutDescend}), 64'd0);
    check("rst_other_outvalid", 64'({bus_s.OutValid, bus_o.OutValid}), 64'd0);
    #9 Reset = 1'b1;
    @(posedge Clk); #1;

    // Basic ascending sort and latency
    send_tbl(0);
    measure_latency("basic_latency", 4);
    drain();

    // Ties in both modes, back to back
    send_tbl(1);
    send_tbl(2);
    drain();

    // Remaining table vectors streamed back to back
    for (int i = 3; i < 9; i++) send_tbl(i);
    drain();

    // Streaming with a 3-cycle output stall once the pipe is full
    sending_done = 1'b0;
    fork
      begin
        send_tbl(4);
        send_tbl(5);
        send_tbl(6);
        for (int i = 0; i < 3; i++) send_rand(15);
      end
      begin
        int w = 0;
        while (!bus.OutValid && w < 50) begin
          @(negedge Clk);
          w++;
        end
        @(posedge Clk); #1;
        bus.OutReady = 1'b0;
        for (int s = 0; s < 3; s++) begin
          @(negedge Clk);
          if (s == 0) held = {bus.Y, bus.YIdx, bus.OutDescend};
          else check("stall_y_stable", 64'({bus.Y, bus.YIdx, bus.OutDescend}), 64'(held));
          check("stall_occ_full", 64'(occ), 64'd4);
          check("stall_inready", 64'(bus.InReady), 64'd0);
          check("stall_outvalid", 64'(bus.OutValid), 64'd1);
          @(posedge Clk); #1;
        end
        bus.OutReady = 1'b1;
        #1;
        check("stall_release_inready", 64'(bus.InReady), 64'd1);
      end
    join
    drain();

    // Random vectors (tie-heavy) under random backpressure
    sending_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 24; i++) send_rand((i % 2 == 0) ? 3 : 15);
        sending_done = 1'b1;
      end
      begin
        while (!sending_done) begin
          bus.OutReady = ($urandom_range(0, 3) != 0);
          @(posedge Clk); #1;
        end
      end
    join
    drain();

    // Reset mid-flight
    bus.OutReady = 1'b1;
    for (int i = 0; i < 3; i++) send_rand(15);
    check("pre_reset_occ", 64'(occ), 64'd3);
    #1 Reset = 1'b0;
    #1;
    check("midrst_outvalid", 64'(bus.OutValid), 64'd0);
    check("midrst_occ", 64'(occ), 64'd0);
    check("midrst_inready", 64'(bus.InReady), 64'd1);
    exp_q.delete();
    #1 Reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge Clk);
      check("post_reset_no_output", 64'(bus.OutValid), 64'd0);
    end
    @(posedge Clk); #1;
    send_tbl(5);
    measure_latency("post_reset_latency", 4);
    drain();

    // Signed instance
    run_signed("signed_asc", k4(15, 2, 8, 0), 1'b0, k4(8, 15, 0, 2), i4(2, 0, 3, 1));
    run_signed("signed_desc", k4(15, 2, 8, 0), 1'b1, k4(2, 0, 15, 8), i4(1, 3, 0, 2));

    // Odd lane count instance
    run_odd("odd_asc", k5(3, 0, 4, 1, 2), 1'b0, k5(0, 1, 2, 3, 4), i5(1, 3, 4, 0, 2));
    run_odd("odd_desc", k5(3, 0, 4, 1, 2), 1'b1, k5(4, 3, 2, 1, 0), i5(2, 0, 4, 3, 1));

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
